intr_priority_arbiter: RTL

Interrupt priority arbiter and APB-configured controller for the interrupt handler. It latches NMI, eight external (IRQ) and eight internal (Int_IRQ) interrupt sources, applies per-source enables and the global mask, and selects one winner by fixed priority. The winner is presented to the CPU as a request plus vector, with an ack/end-of-interrupt handshake. The block sits between the interrupt sources and the CPU; the CPU configures it through its APB slave port.

---
 rtl/intr_pkg.sv | 20 ++
 rtl/intr_prio_enc.sv | 34 +++
 rtl/intr_priority_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/intr_pkg.sv
// Shared constants and types for the interrupt priority arbiter.
package intr_pkg;

  // APB register map
  localparam logic [7:0] ADDR_IRQ_EN   = 8'h00;
  localparam logic [7:0] ADDR_INT_EN   = 8'h01;
  localparam logic [7:0] ADDR_IRQ_PEND = 8'h02;
  localparam logic [7:0] ADDR_INT_PEND = 8'h03;
  localparam logic [7:0] ADDR_VECTOR   = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h05;

  // Interrupt vectors
  localparam logic [7:0] VEC_NMI      = 8'h20;
  localparam logic [7:0] VEC_IRQ_BASE = 8'h10;
  localparam logic [7:0] VEC_INT_BASE = 8'h00;
  localparam logic [7:0] VEC_NONE     = 8'hFF;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: NMI > IRQ[7..0] > Int_IRQ[7..0].
module intr_prio_enc
  import intr_pkg::*;
(
  input  logic       nmi,
  input  logic [7:0] irq,
  input  logic [7:0] int_irq,
  output logic       valid,
  output logic [7:0] vec
);

  // Lowest priority first so higher-priority hits overwrite the result.
  always_comb begin
    valid = 1'b0;
    vec   = VEC_NONE;
    for (int i = 0; i < 8; i++) begin
      if (int_irq[i]) begin
        valid = 1'b1;
        vec   = VEC_INT_BASE + 8'(i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (irq[i]) begin
        valid = 1'b1;
        vec   = VEC_IRQ_BASE + 8'(i);
      end
    end
    if (nmi) begin
      valid = 1'b1;
      vec   = VEC_NMI;
    end
  end

endmodule

// File: rtl/intr_priority_arbiter.sv
// Interrupt priority arbiter with APB configuration and CPU ack/eoi handshake.
module intr_priority_arbiter
  import intr_pkg::*;
(
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  input  logic       NMI,
  input  logic [7:0] IRQ,
  input  logic [7:0] Int_IRQ,
  input  logic       i_bit,
  input  logic       int_ack,
  input  logic       int_eoi,
  output logic       int_req,
  output logic [7:0] int_vec,
  output logic       I_flag,
  output logic       UI_flag
);

  logic [7:0] irq_en_q, int_en_q, irq_pend_q, int_pend_q, irq_prev_q, int_prev_q;
  logic       nmi_pend_q, nmi_prev_q;
  logic [7:0] irq_pend_d, int_pend_d;
  logic       nmi_pend_d;
  state_e     state_q, state_d;
  logic [7:0] vec_q, vec_d;

  logic       access, apb_err, apb_wr;
  logic [7:0] irq_rise, int_rise;
  logic       nmi_rise;
  logic       ack_fire;
  logic       nmi_ack_clr;
  logic [7:0] irq_ack_clr, int_ack_clr, irq_w1c, int_w1c;
  logic [7:0] irq_elig, int_elig;
  logic       enc_valid;
  logic [7:0] enc_vec;
  logic [7:0] rdata;

  assign pready  = 1'b1;
  assign access  = psel & penable;
  assign apb_err = access & ((paddr > ADDR_STATUS) |
                             (pwrite & ((paddr == ADDR_VECTOR) | (paddr == ADDR_STATUS))));
  assign apb_wr  = access & pwrite & ~apb_err;

  assign irq_rise = IRQ & ~irq_prev_q;
  assign int_rise = Int_IRQ & ~int_prev_q;
  assign nmi_rise = NMI & ~nmi_prev_q;

  assign irq_elig = irq_pend_q & irq_en_q & {8{~i_bit}};
  assign int_elig = int_pend_q & int_en_q & {8{~i_bit}};

  intr_prio_enc u_enc (
    .nmi     (nmi_pend_q),
    .irq     (irq_elig),
    .int_irq (int_elig),
    .valid   (enc_valid),
    .vec     (enc_vec)
  );

  // Pending-bit update: W1C and ack-clear first, then new edges win.
  always_comb begin
    ack_fire    = (state_q == REQ) & int_ack;
    nmi_ack_clr = ack_fire & (vec_q == VEC_NMI);
    irq_ack_clr = 8'h00;
    int_ack_clr = 8'h00;
    if (ack_fire && vec_q[7:3] == VEC_IRQ_BASE[7:3]) irq_ack_clr = 8'h01 << vec_q[2:0];
    if (ack_fire && vec_q[7:3] == VEC_INT_BASE[7:3]) int_ack_clr = 8'h01 << vec_q[2:0];
    irq_w1c    = (apb_wr && paddr == ADDR_IRQ_PEND) ? pwdata : 8'h00;
    int_w1c    = (apb_wr && paddr == ADDR_INT_PEND) ? pwdata : 8'h00;
    irq_pend_d = (irq_pend_q & ~irq_w1c & ~irq_ack_clr) | irq_rise;
    int_pend_d = (int_pend_q & ~int_w1c & ~int_ack_clr) | int_rise;
    nmi_pend_d = (nmi_pend_q & ~nmi_ack_clr) | nmi_rise;
  end

  // FSM next state; the vector is latched once on entry to REQ and held.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d = REQ;
          vec_d   = enc_vec;
        end
      end
      REQ:     if (int_ack) state_d = SERVICE;
      SERVICE: if (int_eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, edge history, pending and enable registers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= IDLE;
      vec_q      <= 8'h00;
      irq_en_q   <= 8'h00;
      int_en_q   <= 8'h00;
      irq_pend_q <= 8'h00;
      int_pend_q <= 8'h00;
      nmi_pend_q <= 1'b0;
      irq_prev_q <= 8'h00;
      int_prev_q <= 8'h00;
      nmi_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      irq_pend_q <= irq_pend_d;
      int_pend_q <= int_pend_d;
      nmi_pend_q <= nmi_pend_d;
      irq_prev_q <= IRQ;
      int_prev_q <= Int_IRQ;
      nmi_prev_q <= NMI;
      if (apb_wr && paddr == ADDR_IRQ_EN) irq_en_q <= pwdata;
      if (apb_wr && paddr == ADDR_INT_EN) int_en_q <= pwdata;
    end
  end

  // CPU-facing outputs and flags.
  always_comb begin
    int_req = (state_q == REQ);
    I_flag  = (state_q == SERVICE);
    int_vec = (state_q == IDLE) ? 8'h00 : vec_q;
    UI_flag = i_bit & |((irq_pend_q & irq_en_q) | (int_pend_q & int_en_q));
  end

  // APB read mux; data only driven during a legal read access phase.
  always_comb begin
    case (paddr)
      ADDR_IRQ_EN:   rdata = irq_en_q;
      ADDR_INT_EN:   rdata = int_en_q;
      ADDR_IRQ_PEND: rdata = irq_pend_q;
      ADDR_INT_PEND: rdata = int_pend_q;
      ADDR_VECTOR:   rdata = (state_q == IDLE) ? VEC_NONE : vec_q;
      ADDR_STATUS:   rdata = {5'b0, nmi_pend_q,
                              (state_q == SERVICE) && (vec_q == VEC_NMI),
                              state_q != IDLE};
      default:       rdata = 8'h00;
    endcase
    prdata  = (access & ~pwrite & ~apb_err) ? rdata : 8'h00;
    pslverr = apb_err;
  end

endmodule
